instr_loader: RTL
=================

# instr_loader

Boot-time program loader that fills the instruction cache's write port from a byte stream. It receives a length header, instruction words and a checksum over a valid/ready byte interface. It assembles little-endian 32-bit words, writes each one to consecutive instruction addresses, and holds the core until a complete, verified image is in place. It is the writer end of the instruction store; the fetch stage is the reader.

## Interface
- `WORD_COUNT_MAX`, default 1024: maximum instruction words accepted per image.
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written.
- `clk_i`  in  1  single clock; all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  begin a load; honoured only in IDLE, DONE or ERROR.
- `byte_valid_i`  in  1  `byte_i` holds a valid byte.
- `byte_i`  in  8  stream byte.
- `byte_ready_o`  out  1  loader accepts a byte this cycle.
- `wr_instr_en_o`  out  1  one-cycle write strobe to the instruction cache.
- `wr_addr_o`  out  32  byte address of the word being written.
- `wr_instr_o`  out  32  instruction word being written.
- `busy_o`  out  1  high in LEN, DATA, WRITE and CSUM.
- `done_o`  out  1  image loaded and checksum matched.
- `error_o`  out  1  image rejected.
- `cpu_hold_o`  out  1  holds fetch (PC enable low, flush high) while asserted.

## Operation
- **Reset values:**
  - `byte_ready_o`=0, `wr_instr_en_o`=0, `wr_addr_o`=`BASE_ADDR`, `wr_instr_o`=0.
  - `busy_o`=0, `done_o`=0, `error_o`=0, `cpu_hold_o`=1.
  - State = IDLE.
- **Byte handshake:** a byte is accepted on a rising edge with `byte_valid_i && byte_ready_o`. `byte_ready_o` is high only in LEN, DATA and CSUM.
- **Byte order:** every 4-byte field is little-endian; the first byte goes to bits [7:0]. A 2-bit byte index wraps 3→0.
- **Stream format:** length N (4 bytes), then N words (4 bytes each), then a checksum (4 bytes). The checksum is the sum of all N words mod 2^32.
- **States:**
  - IDLE: on `start_i` go to LEN. Clear word counter, byte index, running sum, `done_o` and `error_o`.
  - LEN: after the 4th byte, if N==0 or N>`WORD_COUNT_MAX` go to ERROR, else go to DATA.
  - DATA: after the 4th byte of a word, go to WRITE.
  - WRITE (one cycle):
    - `wr_instr_en_o`=1, `wr_instr_o`=assembled word, `wr_addr_o`=`BASE_ADDR`+4·index.
    - Add the word to the running sum and increment index.
    - Next state is CSUM if index+1==N, else DATA.
  - CSUM: after the 4th byte, go to DONE if it equals the running sum, else ERROR.
  - DONE: `done_o`=1, `cpu_hold_o`=0. On `start_i` go to LEN and reassert `cpu_hold_o`.
  - ERROR: `error_o`=1, `cpu_hold_o`=1. On `start_i` go to LEN.
- **Mismatch:** words already written are not rolled back; `error_o` marks the image invalid.
- `start_i` while busy is ignored.
- `wr_addr_o` and `wr_instr_o` hold their last values outside WRITE.
- **Widths:** word counter is `$clog2(WORD_COUNT_MAX+1)` bits. The address add is 32-bit and wraps silently. The running sum is 32-bit modular.

## Timing
- **Write latency:** `wr_instr_en_o` is high exactly the cycle after the 4th byte of a word is accepted. A word therefore costs at least 5 cycles, and `byte_ready_o` is 0 during WRITE.
- **Length rejection:** ERROR is entered the cycle after the 4th length byte; `byte_ready_o` is 0 from that cycle.
- **Completion:** `done_o`/`error_o` rise, and `cpu_hold_o` falls (on success), the cycle after the 4th checksum byte. All three are registered.
- **Stalls:** a `byte_valid_i` gap of any length stalls without state change.
- **Reset mid-operation:** `rst_ni` low forces all outputs to reset values immediately, including dropping an in-flight `wr_instr_en_o`. A partial image needs a fresh `start_i`.

## Structure
- Shared package `cpu_pkg` holds the `loader_state_t` enum (IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR) and the `INSTR_WIDTH`=32 constant.
- Sub-module `byte_assembler` holds the 2-bit index and the 32-bit little-endian shift register. It asserts `word_done` on the 4th byte and is reused for the LEN, DATA and CSUM fields.
- The top level holds the FSM, word counter, address generation and checksum accumulator.

## Test plan
- **Good image:** N=2, words 0x00000013 and 0xDEADBEEF, checksum 0xDEADBF02, streamed back-to-back.
  - Writes (0x0, 0x00000013) then (0x4, 0xDEADBEEF), each `wr_instr_en_o` one cycle.
  - Then `done_o`=1, `cpu_hold_o`=0, `error_o`=0.
- **Bad checksum:** same image with checksum 0x00000000. Both writes occur, then `error_o`=1, `done_o`=0, `cpu_hold_o`=1.
- **Length limits:**
  - N=0: ERROR the cycle after the 4th length byte, `byte_ready_o`=0 thereafter, no writes.
  - N=`WORD_COUNT_MAX`+1: same response.
- **Stalls and ignored start:** repeat the good image with random 0–5-cycle `byte_valid_i` gaps and `start_i` pulsed mid-DATA. Writes, addresses and `done_o` are identical to the good-image case.
- **Reset mid-load:** `rst_ni` low after 2 bytes of word 1. All outputs take reset values asynchronously. A following `start_i` plus the full good image completes with `done_o`=1.
- **Reload after success:** `start_i` in DONE with N=1, word 0x00100093, checksum 0x00100093. `cpu_hold_o` returns to 1, one write at 0x0, then `done_o`=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants for the boot loader and its helpers.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Little-endian 4-byte field assembler shared by the length, data and checksum fields.
module byte_assembler
  import cpu_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   byte_en_i,
  input  logic [BYTE_WIDTH-1:0]  byte_i,
  output logic [INSTR_WIDTH-1:0] word_c,
  output logic                   word_done_c
);

  logic [1:0]             idx_q;
  logic [INSTR_WIDTH-1:0] shreg_q;

  // Shifting right places the first byte of the field in bits [7:0] after four bytes.
  assign word_c      = {byte_i, shreg_q[INSTR_WIDTH-1:BYTE_WIDTH]};
  assign word_done_c = byte_en_i && (idx_q == 2'd3);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= 2'd0;
      shreg_q <= '0;
    end else if (clear_i) begin
      idx_q   <= 2'd0;
      shreg_q <= '0;
    end else if (byte_en_i) begin
      idx_q   <= idx_q + 2'd1;
      shreg_q <= word_c;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Boot-time loader: streams a length-prefixed, checksummed image into the instruction store.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int unsigned WORD_COUNT_MAX = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   byte_valid_i,
  input  logic [BYTE_WIDTH-1:0]  byte_i,
  output logic                   byte_ready_o,
  output logic                   wr_instr_en_o,
  output logic [31:0]            wr_addr_o,
  output logic [INSTR_WIDTH-1:0] wr_instr_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   cpu_hold_o
);

  localparam int unsigned CNT_W = $clog2(WORD_COUNT_MAX + 1);

  loader_state_t          state_q, state_d;
  logic [CNT_W-1:0]       word_cnt_q, word_len_q;
  logic [INSTR_WIDTH-1:0] sum_q;
  logic [INSTR_WIDTH-1:0] field_c;
  logic                   word_done_c;
  logic                   accept_c;
  logic                   start_ok_c;

  assign accept_c   = byte_valid_i && byte_ready_o;
  assign start_ok_c = start_i && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));

  byte_assembler u_asm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (start_ok_c),
    .byte_en_i   (accept_c),
    .byte_i      (byte_i),
    .word_c      (field_c),
    .word_done_c (word_done_c)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start_i) state_d = LEN;
      LEN: begin
        if (word_done_c) begin
          if ((field_c == '0) || (field_c > INSTR_WIDTH'(WORD_COUNT_MAX))) state_d = ERROR;
          else                                                             state_d = DATA;
        end
      end
      DATA:  if (word_done_c) state_d = WRITE;
      WRITE: begin
        if ((word_cnt_q + CNT_W'(1)) == word_len_q) state_d = CSUM;
        else                                         state_d = DATA;
      end
      CSUM:  if (word_done_c) state_d = (field_c == sum_q) ? DONE : ERROR;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered copies of the decoded next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_ready_o  <= 1'b0;
      wr_instr_en_o <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
      cpu_hold_o    <= 1'b1;
    end else begin
      byte_ready_o  <= (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
      wr_instr_en_o <= (state_d == WRITE);
      busy_o        <= (state_d == LEN) || (state_d == DATA) || (state_d == WRITE) ||
                       (state_d == CSUM);
      done_o        <= (state_d == DONE);
      error_o       <= (state_d == ERROR);
      cpu_hold_o    <= (state_d != DONE);
    end
  end

  // Word counter, address/data latch and running checksum
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_cnt_q <= '0;
      word_len_q <= '0;
      sum_q      <= '0;
      wr_addr_o  <= BASE_ADDR;
      wr_instr_o <= '0;
    end else begin
      if (start_ok_c) begin
        word_cnt_q <= '0;
        word_len_q <= '0;
        sum_q      <= '0;
      end
      // Truncation is safe: an out-of-range length never leaves LEN for DATA.
      if ((state_q == LEN) && word_done_c) word_len_q <= CNT_W'(field_c);
      if ((state_q == DATA) && word_done_c) begin
        wr_instr_o <= field_c;
        wr_addr_o  <= BASE_ADDR + (32'(word_cnt_q) << 2);
      end
      if (state_q == WRITE) begin
        sum_q      <= sum_q + wr_instr_o;
        word_cnt_q <= word_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
